aes_top: RTL and testbench

Iterative AES-128 encryption core (FIPS-197, encrypt only) computing one round per clock with on-the-fly key expansion. It accepts a 128-bit plaintext and 128-bit key on a level-sensitive enable and returns the ciphertext with a one-cycle valid pulse. It is the top of the AES datapath and is driven directly by the system controller or bench.

---
 rtl/aes_pkg.sv | 38 +++
 rtl/aes_sbox.sv | 29 ++
 rtl/aes_top.sv | 106 ++++++++++
 tb/tb_aes_top.sv | 144 ++++++++++++++
 4 files changed

// File: rtl/aes_pkg.sv
// Shared AES-128 types, constants and GF(2^8) helpers used by the encrypt core.
package aes_pkg;

   localparam logic [3:0] NR = 4'd10;

   typedef logic [127:0] block_t;
   typedef enum logic {ST_IDLE, ST_BUSY} aes_fsm_e;

   function automatic logic [7:0] rcon(input logic [3:0] round);
      case (round)
         4'd1:    return 8'h01;
         4'd2:    return 8'h02;
         4'd3:    return 8'h04;
         4'd4:    return 8'h08;
         4'd5:    return 8'h10;
         4'd6:    return 8'h20;
         4'd7:    return 8'h40;
         4'd8:    return 8'h80;
         4'd9:    return 8'h1b;
         4'd10:   return 8'h36;
         default: return 8'h00;
      endcase
   endfunction

   function automatic logic [7:0] xtime(input logic [7:0] b);
      return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
   endfunction

   // Byte i of a block sits at bits [127-8i -: 8]; it maps to row i%4, column i/4.
   function automatic int byte_idx(input int row, input int col);
      return 4 * col + row;
   endfunction

   function automatic logic [7:0] get_byte(input block_t b, input int i);
      return b[127 - 8 * i -: 8];
   endfunction

endpackage

// File: rtl/aes_sbox.sv
// Combinational forward AES S-box, one byte per instance.
module aes_sbox (
   input  logic [7:0] b,
   output logic [7:0] s
);

   always_comb begin
      s = 8'h00;
      case (b)
         8'h00: s = 8'h63; 8'h01: s = 8'h7c; 8'h02: s = 8'h77; 8'h03: s = 8'h7b; 8'h04: s = 8'hf2; 8'h05: s = 8'h6b; 8'h06: s = 8'h6f; 8'h07: s = 8'hc5; 8'h08: s = 8'h30; 8'h09: s = 8'h01; 8'h0a: s = 8'h67; 8'h0b: s = 8'h2b; 8'h0c: s = 8'hfe; 8'h0d: s = 8'hd7; 8'h0e: s = 8'hab; 8'h0f: s = 8'h76;
         8'h10: s = 8'hca; 8'h11: s = 8'h82; 8'h12: s = 8'hc9; 8'h13: s = 8'h7d; 8'h14: s = 8'hfa; 8'h15: s = 8'h59; 8'h16: s = 8'h47; 8'h17: s = 8'hf0; 8'h18: s = 8'had; 8'h19: s = 8'hd4; 8'h1a: s = 8'ha2; 8'h1b: s = 8'haf; 8'h1c: s = 8'h9c; 8'h1d: s = 8'ha4; 8'h1e: s = 8'h72; 8'h1f: s = 8'hc0;
         8'h20: s = 8'hb7; 8'h21: s = 8'hfd; 8'h22: s = 8'h93; 8'h23: s = 8'h26; 8'h24: s = 8'h36; 8'h25: s = 8'h3f; 8'h26: s = 8'hf7; 8'h27: s = 8'hcc; 8'h28: s = 8'h34; 8'h29: s = 8'ha5; 8'h2a: s = 8'he5; 8'h2b: s = 8'hf1; 8'h2c: s = 8'h71; 8'h2d: s = 8'hd8; 8'h2e: s = 8'h31; 8'h2f: s = 8'h15;
         8'h30: s = 8'h04; 8'h31: s = 8'hc7; 8'h32: s = 8'h23; 8'h33: s = 8'hc3; 8'h34: s = 8'h18; 8'h35: s = 8'h96; 8'h36: s = 8'h05; 8'h37: s = 8'h9a; 8'h38: s = 8'h07; 8'h39: s = 8'h12; 8'h3a: s = 8'h80; 8'h3b: s = 8'he2; 8'h3c: s = 8'heb; 8'h3d: s = 8'h27; 8'h3e: s = 8'hb2; 8'h3f: s = 8'h75;
         8'h40: s = 8'h09; 8'h41: s = 8'h83; 8'h42: s = 8'h2c; 8'h43: s = 8'h1a; 8'h44: s = 8'h1b; 8'h45: s = 8'h6e; 8'h46: s = 8'h5a; 8'h47: s = 8'ha0; 8'h48: s = 8'h52; 8'h49: s = 8'h3b; 8'h4a: s = 8'hd6; 8'h4b: s = 8'hb3; 8'h4c: s = 8'h29; 8'h4d: s = 8'he3; 8'h4e: s = 8'h2f; 8'h4f: s = 8'h84;
         8'h50: s = 8'h53; 8'h51: s = 8'hd1; 8'h52: s = 8'h00; 8'h53: s = 8'hed; 8'h54: s = 8'h20; 8'h55: s = 8'hfc; 8'h56: s = 8'hb1; 8'h57: s = 8'h5b; 8'h58: s = 8'h6a; 8'h59: s = 8'hcb; 8'h5a: s = 8'hbe; 8'h5b: s = 8'h39; 8'h5c: s = 8'h4a; 8'h5d: s = 8'h4c; 8'h5e: s = 8'h58; 8'h5f: s = 8'hcf;
         8'h60: s = 8'hd0; 8'h61: s = 8'hef; 8'h62: s = 8'haa; 8'h63: s = 8'hfb; 8'h64: s = 8'h43; 8'h65: s = 8'h4d; 8'h66: s = 8'h33; 8'h67: s = 8'h85; 8'h68: s = 8'h45; 8'h69: s = 8'hf9; 8'h6a: s = 8'h02; 8'h6b: s = 8'h7f; 8'h6c: s = 8'h50; 8'h6d: s = 8'h3c; 8'h6e: s = 8'h9f; 8'h6f: s = 8'ha8;
         8'h70: s = 8'h51; 8'h71: s = 8'ha3; 8'h72: s = 8'h40; 8'h73: s = 8'h8f; 8'h74: s = 8'h92; 8'h75: s = 8'h9d; 8'h76: s = 8'h38; 8'h77: s = 8'hf5; 8'h78: s = 8'hbc; 8'h79: s = 8'hb6; 8'h7a: s = 8'hda; 8'h7b: s = 8'h21; 8'h7c: s = 8'h10; 8'h7d: s = 8'hff; 8'h7e: s = 8'hf3; 8'h7f: s = 8'hd2;
         8'h80: s = 8'hcd; 8'h81: s = 8'h0c; 8'h82: s = 8'h13; 8'h83: s = 8'hec; 8'h84: s = 8'h5f; 8'h85: s = 8'h97; 8'h86: s = 8'h44; 8'h87: s = 8'h17; 8'h88: s = 8'hc4; 8'h89: s = 8'ha7; 8'h8a: s = 8'h7e; 8'h8b: s = 8'h3d; 8'h8c: s = 8'h64; 8'h8d: s = 8'h5d; 8'h8e: s = 8'h19; 8'h8f: s = 8'h73;
         8'h90: s = 8'h60; 8'h91: s = 8'h81; 8'h92: s = 8'h4f; 8'h93: s = 8'hdc; 8'h94: s = 8'h22; 8'h95: s = 8'h2a; 8'h96: s = 8'h90; 8'h97: s = 8'h88; 8'h98: s = 8'h46; 8'h99: s = 8'hee; 8'h9a: s = 8'hb8; 8'h9b: s = 8'h14; 8'h9c: s = 8'hde; 8'h9d: s = 8'h5e; 8'h9e: s = 8'h0b; 8'h9f: s = 8'hdb;
         8'ha0: s = 8'he0; 8'ha1: s = 8'h32; 8'ha2: s = 8'h3a; 8'ha3: s = 8'h0a; 8'ha4: s = 8'h49; 8'ha5: s = 8'h06; 8'ha6: s = 8'h24; 8'ha7: s = 8'h5c; 8'ha8: s = 8'hc2; 8'ha9: s = 8'hd3; 8'haa: s = 8'hac; 8'hab: s = 8'h62; 8'hac: s = 8'h91; 8'had: s = 8'h95; 8'hae: s = 8'he4; 8'haf: s = 8'h79;
         8'hb0: s = 8'he7; 8'hb1: s = 8'hc8; 8'hb2: s = 8'h37; 8'hb3: s = 8'h6d; 8'hb4: s = 8'h8d; 8'hb5: s = 8'hd5; 8'hb6: s = 8'h4e; 8'hb7: s = 8'ha9; 8'hb8: s = 8'h6c; 8'hb9: s = 8'h56; 8'hba: s = 8'hf4; 8'hbb: s = 8'hea; 8'hbc: s = 8'h65; 8'hbd: s = 8'h7a; 8'hbe: s = 8'hae; 8'hbf: s = 8'h08;
         8'hc0: s = 8'hba; 8'hc1: s = 8'h78; 8'hc2: s = 8'h25; 8'hc3: s = 8'h2e; 8'hc4: s = 8'h1c; 8'hc5: s = 8'ha6; 8'hc6: s = 8'hb4; 8'hc7: s = 8'hc6; 8'hc8: s = 8'he8; 8'hc9: s = 8'hdd; 8'hca: s = 8'h74; 8'hcb: s = 8'h1f; 8'hcc: s = 8'h4b; 8'hcd: s = 8'hbd; 8'hce: s = 8'h8b; 8'hcf: s = 8'h8a;
         8'hd0: s = 8'h70; 8'hd1: s = 8'h3e; 8'hd2: s = 8'hb5; 8'hd3: s = 8'h66; 8'hd4: s = 8'h48; 8'hd5: s = 8'h03; 8'hd6: s = 8'hf6; 8'hd7: s = 8'h0e; 8'hd8: s = 8'h61; 8'hd9: s = 8'h35; 8'hda: s = 8'h57; 8'hdb: s = 8'hb9; 8'hdc: s = 8'h86; 8'hdd: s = 8'hc1; 8'hde: s = 8'h1d; 8'hdf: s = 8'h9e;
         8'he0: s = 8'he1; 8'he1: s = 8'hf8; 8'he2: s = 8'h98; 8'he3: s = 8'h11; 8'he4: s = 8'h69; 8'he5: s = 8'hd9; 8'he6: s = 8'h8e; 8'he7: s = 8'h94; 8'he8: s = 8'h9b; 8'he9: s = 8'h1e; 8'hea: s = 8'h87; 8'heb: s = 8'he9; 8'hec: s = 8'hce; 8'hed: s = 8'h55; 8'hee: s = 8'h28; 8'hef: s = 8'hdf;
         8'hf0: s = 8'h8c; 8'hf1: s = 8'ha1; 8'hf2: s = 8'h89; 8'hf3: s = 8'h0d; 8'hf4: s = 8'hbf; 8'hf5: s = 8'he6; 8'hf6: s = 8'h42; 8'hf7: s = 8'h68; 8'hf8: s = 8'h41; 8'hf9: s = 8'h99; 8'hfa: s = 8'h2d; 8'hfb: s = 8'h0f; 8'hfc: s = 8'hb0; 8'hfd: s = 8'h54; 8'hfe: s = 8'hbb; 8'hff: s = 8'h16;
      endcase
   end

endmodule

// File: rtl/aes_top.sv
// Iterative AES-128 encrypt core: one round per clock, key schedule expanded on the fly.
module aes_top
   import aes_pkg::*;
(
   input  logic         AES_clk,
   input  logic         AES_rst_n,
   input  logic         AES_en,
   input  logic [127:0] AES_data_in,
   input  logic [127:0] AES_key_in,
   output logic [127:0] AES_data_out,
   output logic         AES_data_out_valid
);

   aes_fsm_e   fsm_q;
   logic [3:0] round_q;
   block_t     blk_q;
   block_t     rk_q;

   logic [7:0]  sub_b [16];
   logic [31:0] rot_w;
   logic [31:0] sub_w;
   logic [31:0] key_t;
   block_t      sr;
   block_t      mc;
   block_t      next_key;
   block_t      round_out;

   function automatic logic [31:0] mix_column(input logic [31:0] col);
      logic [7:0] a0, a1, a2, a3;
      {a0, a1, a2, a3} = col;
      return {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
              a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
              a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
              xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
   endfunction

   for (genvar gi = 0; gi < 16; gi++) begin : g_subbytes
      aes_sbox u_sbox (.b(blk_q[127 - 8 * gi -: 8]), .s(sub_b[gi]));
   end

   for (genvar gk = 0; gk < 4; gk++) begin : g_subword
      aes_sbox u_sbox (.b(rot_w[31 - 8 * gk -: 8]), .s(sub_w[31 - 8 * gk -: 8]));
   end

   // Key schedule: each word chains off the previous new word.
   assign rot_w = {rk_q[23:0], rk_q[31:24]};
   assign key_t = sub_w ^ {rcon(round_q), 24'h000000};
   assign next_key[127:96] = rk_q[127:96] ^ key_t;
   assign next_key[95:64]  = rk_q[95:64]  ^ next_key[127:96];
   assign next_key[63:32]  = rk_q[63:32]  ^ next_key[95:64];
   assign next_key[31:0]   = rk_q[31:0]   ^ next_key[63:32];

   always_comb begin
      sr = '0;
      mc = '0;
      for (int c = 0; c < 4; c++) begin
         for (int r = 0; r < 4; r++) begin
            sr[127 - 8 * byte_idx(r, c) -: 8] = sub_b[byte_idx(r, (c + r) % 4)];
         end
      end
      for (int c = 0; c < 4; c++) begin
         mc[127 - 32 * c -: 32] = mix_column(sr[127 - 32 * c -: 32]);
      end
   end

   assign round_out = ((round_q == NR) ? sr : mc) ^ next_key;

   always_ff @(posedge AES_clk or negedge AES_rst_n) begin
      if (!AES_rst_n) begin
         fsm_q              <= ST_IDLE;
         round_q            <= 4'd0;
         blk_q              <= '0;
         rk_q               <= '0;
         AES_data_out       <= '0;
         AES_data_out_valid <= 1'b0;
      end else begin
         AES_data_out_valid <= 1'b0;
         case (fsm_q)
            ST_IDLE: begin
               if (AES_en) begin
                  blk_q   <= AES_data_in ^ AES_key_in;
                  rk_q    <= AES_key_in;
                  round_q <= 4'd1;
                  fsm_q   <= ST_BUSY;
               end
            end
            ST_BUSY: begin
               blk_q   <= round_out;
               rk_q    <= next_key;
               round_q <= round_q + 4'd1;
               if (round_q == NR) begin
                  AES_data_out       <= round_out;
                  AES_data_out_valid <= 1'b1;
                  round_q            <= 4'd0;
                  fsm_q              <= ST_IDLE;
               end
            end
            default: fsm_q <= ST_IDLE;
         endcase
      end
   end

   logic unused_pkg;
   assign unused_pkg = ^get_byte(blk_q, 0);

endmodule

// File: tb/tb_aes_top.sv
// Directed-vector bench for aes_top using FIPS-197 known-answer vectors.
module tb_aes_top;

   logic         clk;
   logic         rst_n;
   logic         en;
   logic [127:0] din;
   logic [127:0] key;
   logic [127:0] dout;
   logic         valid;

   int n_chk;
   int n_pass;

   localparam logic [127:0] KEY_B = 128'h2b7e151628aed2a6abf7158809cf4f3c;
   localparam logic [127:0] PT_B  = 128'h3243f6a8885a308d313198a2e0370734;
   localparam logic [127:0] CT_B  = 128'h3925841d02dc09fbdc118597196a0b32;
   localparam logic [127:0] KEY_C = 128'h000102030405060708090a0b0c0d0e0f;
   localparam logic [127:0] PT_C  = 128'h00112233445566778899aabbccddeeff;
   localparam logic [127:0] CT_C  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
   localparam logic [127:0] CT_0  = 128'h66e94bd4ef8a2c3b884cfa59ca342b2e;

   aes_top dut (
      .AES_clk(clk),
      .AES_rst_n(rst_n),
      .AES_en(en),
      .AES_data_in(din),
      .AES_key_in(key),
      .AES_data_out(dout),
      .AES_data_out_valid(valid)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", tag, got, exp);
   endtask

   // One-cycle enable pulse, then a bounded wait for the result.
   task automatic run_block(input string tag, input logic [127:0] k, input logic [127:0] pt,
                            input logic [127:0] exp);
      int lat;
      lat = 0;
      @(negedge clk);
      key = k; din = pt; en = 1'b1;
      @(posedge clk); #1;
      en = 1'b0;
      do begin
         @(posedge clk); #1;
         lat++;
      end while (!valid && lat < 20);
      check({tag, " latency"}, 128'(lat), 128'd10);
      check({tag, " out"}, dout, exp);
      @(posedge clk); #1;
      check({tag, " pulse width"}, 128'(valid), 128'd0);
   endtask

   initial begin
      int npulse, last_pulse, lat;
      n_chk = 0; n_pass = 0;
      rst_n = 1'b1; en = 1'b0; din = '0; key = '0;
      #2 rst_n = 1'b0;
      #1;
      check("reset out", dout, 128'd0);
      check("reset valid", 128'(valid), 128'd0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      check("idle out", dout, 128'd0);
      check("idle valid", 128'(valid), 128'd0);

      run_block("zero", 128'd0, 128'd0, CT_0);
      run_block("appB", KEY_B, PT_B, CT_B);
      run_block("c1", KEY_C, PT_C, CT_C);

      // Back-to-back with en held; inputs disturbed while busy.
      npulse = 0; last_pulse = 0;
      @(negedge clk);
      key = KEY_B; din = PT_B; en = 1'b1;
      for (int i = 1; i <= 50; i++) begin
         @(posedge clk); #1;
         if (valid) begin
            npulse++;
            check("burst out", dout, CT_B);
            if (last_pulse != 0) check("burst interval", 128'(i - last_pulse), 128'd11);
            last_pulse = i;
         end
         if (i == 3) begin din = ~PT_B; key = ~KEY_B; end
         if (i == 8) begin din = PT_B; key = KEY_B; end
      end
      en = 1'b0;
      check("burst pulse count", 128'(npulse), 128'd4);
      repeat (12) @(posedge clk);
      #1;
      check("burst drain out", dout, CT_B);

      // Asynchronous reset in round 5.
      @(negedge clk);
      key = KEY_C; din = PT_C; en = 1'b1;
      @(posedge clk); #1;
      en = 1'b0;
      repeat (4) @(posedge clk);
      #3 rst_n = 1'b0;
      #1;
      check("midreset out", dout, 128'd0);
      check("midreset valid", 128'(valid), 128'd0);
      @(negedge clk);
      rst_n = 1'b1;
      npulse = 0;
      for (int i = 0; i < 15; i++) begin
         @(posedge clk); #1;
         if (valid) npulse++;
      end
      check("post-reset no pulse", 128'(npulse), 128'd0);
      run_block("after reset", KEY_B, PT_B, CT_B);

      // en dropped mid-block: block finishes, nothing restarts.
      @(negedge clk);
      key = KEY_C; din = PT_C; en = 1'b1;
      repeat (3) @(posedge clk);
      #1 en = 1'b0;
      lat = 0;
      do begin
         @(posedge clk); #1;
         lat++;
      end while (!valid && lat < 20);
      check("en drop valid", 128'(valid), 128'd1);
      check("en drop out", dout, CT_C);
      npulse = 0;
      for (int i = 0; i < 15; i++) begin
         @(posedge clk); #1;
         if (valid) npulse++;
      end
      check("en drop no restart", 128'(npulse), 128'd0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
